// File: rtl/gray_dec_pkg.sv
// Shared types and helpers for the 2x2 grayscale decimator.
//
// Contents:
//   pixel_t    - 8-bit gray pixel
//   pair_sum_t - 9-bit sum of two horizontally adjacent pixels
//   quad_sum_t - 10-bit sum of a full 2x2 block (max 1020)
//   cnt_w()    - counter/address width for a range of n values, never zero
//   quad_avg() - 2x2 block sum to averaged pixel
//
// Build option: GRAY_DEC_ROUND_EN selects round-half-up averaging;
// without it the average truncates.
package gray_dec_pkg;

  typedef logic [7:0] pixel_t;
  typedef logic [8:0] pair_sum_t;
  typedef logic [9:0] quad_sum_t;

  // A dimension of 1 still needs a one-bit counter/address.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // (1020 + 2) >> 2 = 255, so neither mode can overflow 8 bits.
  function automatic pixel_t quad_avg(input quad_sum_t s);
    quad_sum_t r;
`ifdef GRAY_DEC_ROUND_EN
    r = s + 10'd2;
`else
    r = s;
`endif
    return pixel_t'(r >> 2);
  endfunction

endpackage

// File: rtl/gray_dec_line_buf.sv
// Line buffer of horizontal pair sums for the 2x2 decimator.
// Simple dual-port RAM: one write port, one read port with a registered
// read (data valid the cycle after rd_en). No reset on the storage or the
// read register, so it maps onto block RAM.
//
// Ports:
//   clk     - clock
//   wr_en   - write strobe
//   wr_addr - write address
//   wr_data - 9-bit pair sum to store
//   rd_en   - read strobe; rd_data holds its value while rd_en is low
//   rd_addr - read address
//   rd_data - registered read data
module gray_dec_line_buf
  import gray_dec_pkg::*;
#(
  parameter int depth  = 120,
  parameter int addr_w = 7
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [addr_w-1:0] wr_addr,
  input  logic [8:0]        wr_data,
  input  logic              rd_en,
  input  logic [addr_w-1:0] rd_addr,
  output logic [8:0]        rd_data
);

  pair_sum_t mem [depth];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/gray_decimator_2x2.sv
// 2x2 box-average decimator for a raster 8-bit grayscale stream.
// Produces a (in_w/2) x (in_h/2) frame; each output pixel is the average
// of one 2x2 input block. Even rows store horizontal pair sums in a line
// buffer; odd rows read them back and complete the 2x2 sum.
//
// Build option: GRAY_DEC_ROUND_EN -> round-half-up average, else truncate.
//
// Ports:
//   clk        - clock, rising edge
//   reset      - asynchronous active-low reset
//   sync_clear - synchronous frame resync: clears counters and pending output
//   in_data    - full-resolution pixel, raster order
//   in_valid   - in_data valid
//   in_ready   - block accepts in_data this cycle
//   out_data   - decimated pixel (registered)
//   out_valid  - out_data valid (registered)
//   out_ready  - downstream accepts out_data
//   frame_done - one-cycle pulse after the last output pixel of a frame is accepted
//
// Handshake: a beat happens on a side when valid && ready are both high at
// a rising edge. The producer holds data stable while valid && !ready.
// in_ready = !out_valid || out_ready, so a result can only be loaded when
// the single-entry output register is empty or being drained that edge.
module gray_decimator_2x2
  import gray_dec_pkg::*;
#(
  parameter int in_w = 240,
  parameter int in_h = 480
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sync_clear,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       frame_done
);

  localparam int out_w     = in_w / 2;
  localparam int out_h     = in_h / 2;
  localparam int lb_addr_w = cnt_w(out_w);
  localparam int x_w       = cnt_w(in_w);
  localparam int y_w       = cnt_w(in_h);
  localparam int ox_w      = cnt_w(out_w);
  localparam int oy_w      = cnt_w(out_h);

  localparam logic [x_w-1:0]  x_last  = x_w'(in_w - 1);
  localparam logic [y_w-1:0]  y_last  = y_w'(in_h - 1);
  localparam logic [ox_w-1:0] ox_last = ox_w'(out_w - 1);
  localparam logic [oy_w-1:0] oy_last = oy_w'(out_h - 1);

  logic [x_w-1:0]       x_cnt;
  logic [y_w-1:0]       y_cnt;
  logic [ox_w-1:0]      ox_cnt;
  logic [oy_w-1:0]      oy_cnt;
  pixel_t               h_reg;
  pair_sum_t            lb_q;
  pair_sum_t            pair_sum;
  quad_sum_t            quad_sum;
  logic [lb_addr_w-1:0] lb_addr;
  logic                 in_beat;
  logic                 out_beat;
  logic                 odd_row;
  logic                 odd_col;
  logic                 lb_wr_en;
  logic                 lb_rd_en;
  logic                 load;

  assign in_ready = !out_valid || out_ready;

  // sync_clear wins over both beats: the input pixel is dropped and the
  // pending output is discarded rather than counted.
  assign in_beat  = in_valid && in_ready && !sync_clear;
  assign out_beat = out_valid && out_ready && !sync_clear;

  assign odd_row  = y_cnt[0];
  assign odd_col  = x_cnt[0];
  assign lb_addr  = lb_addr_w'(x_cnt >> 1);

  assign pair_sum = pair_sum_t'(h_reg) + pair_sum_t'(in_data);
  assign quad_sum = quad_sum_t'(lb_q) + quad_sum_t'(h_reg) + quad_sum_t'(in_data);

  // Even row, odd column: store the finished pair. Odd row, even column:
  // fetch the pair from above; it is ready in lb_q by the odd-column beat
  // and is held there even if that beat is delayed.
  assign lb_wr_en = in_beat && !odd_row && odd_col;
  assign lb_rd_en = in_beat && odd_row && !odd_col;
  assign load     = in_beat && odd_row && odd_col;

  gray_dec_line_buf #(
    .depth  (out_w),
    .addr_w (lb_addr_w)
  ) u_line_buf (
    .clk     (clk),
    .wr_en   (lb_wr_en),
    .wr_addr (lb_addr),
    .wr_data (pair_sum),
    .rd_en   (lb_rd_en),
    .rd_addr (lb_addr),
    .rd_data (lb_q)
  );

  // Input raster position and left pixel of the current pair.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_cnt <= '0;
      y_cnt <= '0;
      h_reg <= '0;
    end else if (sync_clear) begin
      x_cnt <= '0;
      y_cnt <= '0;
      h_reg <= '0;
    end else if (in_beat) begin
      if (!odd_col) begin
        h_reg <= in_data;
      end
      if (x_cnt == x_last) begin
        x_cnt <= '0;
        y_cnt <= (y_cnt == y_last) ? '0 : y_cnt + 1'b1;
      end else begin
        x_cnt <= x_cnt + 1'b1;
      end
    end
  end

  // Output register, output raster position and end-of-frame pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_data   <= '0;
      out_valid  <= 1'b0;
      ox_cnt     <= '0;
      oy_cnt     <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (sync_clear) begin
        out_data  <= '0;
        out_valid <= 1'b0;
        ox_cnt    <= '0;
        oy_cnt    <= '0;
      end else begin
        // A load can coincide with draining the previous result; the
        // register then stays full with the new value.
        if (load) begin
          out_data  <= quad_avg(quad_sum);
          out_valid <= 1'b1;
        end else if (out_beat) begin
          out_valid <= 1'b0;
        end
        if (out_beat) begin
          if (ox_cnt == ox_last) begin
            ox_cnt <= '0;
            if (oy_cnt == oy_last) begin
              oy_cnt     <= '0;
              frame_done <= 1'b1;
            end else begin
              oy_cnt <= oy_cnt + 1'b1;
            end
          end else begin
            ox_cnt <= ox_cnt + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: doc/gray_decimator_2x2.md
Name: gray_decimator_2x2

Overview:
- Upstream feeder for the grayscale input of the BRAM filter system.
- Takes a full-resolution 8-bit grayscale raster stream and emits a 2x2 box-averaged stream at half width and half height, i.e. the decimated frame (dec_frame_w x dec_frame_h) that the filter stage consumes on gray_in_*.
- Uses a single line buffer of horizontal pair sums and valid/ready handshakes on both sides.

Parameters:
- in_w, 240, full-resolution frame width in pixels; must be even and >= 2.
- in_h, 480, full-resolution frame height in rows; must be even and >= 2.
- (localparams) out_w = in_w/2, out_h = in_h/2, lb_addr_w = $clog2(out_w).

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- sync_clear  in  1  synchronous frame resync; zeroes counters and the pending output.
- in_data  in  8  full-resolution gray pixel, raster order.
- in_valid  in  1  in_data valid.
- in_ready  out  1  block accepts in_data this cycle.
- out_data  out  8  decimated gray pixel.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts out_data.
- frame_done  out  1  one-cycle pulse when the last output pixel of a frame is accepted.

Behaviour:
- Reset (reset low, async):
  - x_cnt, y_cnt, ox_cnt, oy_cnt = 0; h_reg = 0.
  - out_valid = 0, out_data = 0, frame_done = 0.
  - in_ready = 1 once reset is released.
  - Line buffer contents are don't-care.
- Handshakes:
  - Input beat on in_valid && in_ready.
  - in_ready = !out_valid || out_ready (combinational).
  - The output register is single-entry; out_data/out_valid are registered.
  - out_data stays stable while out_valid && !out_ready.
- Counters:
  - x_cnt wraps at in_w-1 and increments y_cnt; y_cnt wraps at in_h-1 to 0, which is the frame boundary.
  - Counters advance only on input beats.
- Even row (y_cnt[0]=0):
  - Even column: h_reg <= in_data.
  - Odd column: line_buf[x_cnt>>1] <= h_reg + in_data (9 bits).
  - No output on even rows.
- Odd row:
  - Even column: h_reg <= in_data, and a read of line_buf[x_cnt>>1] is issued (1-cycle read latency; result held in lb_q).
  - Odd column: sum = lb_q + h_reg + in_data (10 bits, no overflow).
  - Result is loaded into out_data and out_valid <= 1 on the same edge as the input beat.
- Latency: one cycle from the odd-row/odd-column input beat to out_valid.
- Output arithmetic: out_data = sum >> 2 (truncate). Max sum 1020 gives 255, so no saturation is needed.
- Output beat: on out_valid && out_ready, out_valid <= 0 unless a new result loads on the same edge, in which case it stays 1 with the new data.
- Output counters:
  - ox_cnt/oy_cnt advance per output beat.
  - frame_done is asserted for 1 cycle on the edge after the beat with ox_cnt = out_w-1 and oy_cnt = out_h-1; both counters then wrap to 0.
- sync_clear:
  - Has priority over any beat in the same cycle; that input beat is dropped.
  - Clears all counters and h_reg, and sets out_valid = 0.
  - frame_done is not pulsed.
- Back-to-back frames: no bubble is required between frames; line buffer contents are simply overwritten by the next even row.
- Reset mid-frame: identical to power-up; the partial frame is discarded.

Optional Feature:
- Macro: GRAY_DEC_ROUND_EN.
- Defined: out_data = (sum + 2) >> 2, round-half-up. Max (1020+2)>>2 = 255, so still no saturation.
- Undefined: truncation, out_data = sum >> 2.

Decomposition:
- Shared package gray_dec_pkg:
  - typedef pixel_t (logic [7:0]).
  - typedef pair_sum_t (logic [8:0]).
  - typedef quad_sum_t (logic [9:0]).
- Sub-module gray_dec_line_buf: out_w x 9-bit simple dual-port RAM, 1 write port, 1 read port, registered read (1-cycle latency); inferable as BRAM.

Test Plan:
- Basic average:
  - in_w=4, in_h=2.
  - Rows {10,20,30,40} and {50,60,70,80} with out_ready=1.
  - Expect out = 35, 55; frame_done pulses once after 55.
- Rounding:
  - 2x2 block {1,2,2,2}, sum 7.
  - Expect out = 1 without GRAY_DEC_ROUND_EN, 2 with it.
- Saturation bound: all pixels 255 with in_w=240, in_h=480 → 28800 outputs, all 255; exactly one frame_done.
- Backpressure:
  - Hold out_ready=0 while out_valid=1.
  - Expect in_ready=0 and out_data stable.
  - Release out_ready: the held value is accepted, then streaming resumes with no lost or duplicated pixels.
- Random valid gaps over 2 consecutive frames vs. a reference model: bit-exact outputs, frame_done after each frame's last beat, no bubble required between frames.
- Resync/reset mid-frame:
  - Assert sync_clear, then separately pulse reset low, each at row 3 column 5.
  - Expect out_valid=0 and counters=0.
  - A following full frame produces correct averages with no frame_done from the aborted frame.
